// File: rtl/ssd_pkg.sv
// Shared types, segment encodings and scan-state encoding for the seven-segment scanner.
// Segment vectors are {a,b,c,d,e,f,g}, active-low (common-anode).
package ssd_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   localparam seg_t HEX_SEG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   typedef enum logic {
      ST_UNPRIMED = 1'b0,
      ST_RUN      = 1'b1
   } scan_state_t;

   function automatic seg_t hex2seg(input logic [3:0] nibble);
      return HEX_SEG[nibble];
   endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   always_comb begin
      seg = hex2seg(nibble);
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with frame-coherent input snapshot.
// Optional macro SSD_BRIGHTNESS_PWM_EN adds a 4-bit brightness input gating the post-blank slot.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 8,
   parameter int unsigned SCAN_DIV_BITS = 18,
   parameter int unsigned BLANK_CYCLES  = 1024
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_blank_en,
`ifdef SSD_BRIGHTNESS_PWM_EN
   input  logic [3:0]              brightness,
`endif
   output logic [NUM_DIGITS-1:0]   an,
   output seg_t                    seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SCAN_DIV_BITS-1:0] BLANK_END = SCAN_DIV_BITS'(BLANK_CYCLES);
   localparam logic [NUM_DIGITS-1:0]    AN_LSB    = NUM_DIGITS'(1);

   logic [SCAN_DIV_BITS-1:0] presc;
   logic [IDX_W-1:0]         idx;
   scan_state_t              state, state_next;
   logic                     capture;
   logic                     slot_end;
   logic                     frame_wrap;

   logic [4*NUM_DIGITS-1:0]  snap_value;
   logic [NUM_DIGITS-1:0]    snap_dp;
   logic [NUM_DIGITS-1:0]    snap_en;
   logic                     snap_lz;

   logic [NUM_DIGITS-1:0]    lz_mask;
   logic                     seen_nz;
   logic [3:0]               cur_nib;
   seg_t                     cur_seg;
   logic                     pwm_on;
   logic                     visible;

   assign slot_end   = &presc;
   assign frame_wrap = slot_end && (idx == LAST_IDX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_UNPRIMED;
      end else begin
         state <= state_next;
      end
   end

   // The priming edge loads the snapshot once; afterwards only frame wraps do.
   always_comb begin
      state_next = state;
      capture    = frame_wrap;
      if (state == ST_UNPRIMED) begin
         capture    = 1'b1;
         state_next = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc      <= '0;
         idx        <= '0;
         snap_value <= '0;
         snap_dp    <= '0;
         snap_en    <= '0;
         snap_lz    <= 1'b0;
      end else begin
         presc <= presc + 1'b1;
         if (slot_end) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
         if (capture) begin
            snap_value <= value;
            snap_dp    <= dp_in;
            snap_en    <= digit_en;
            snap_lz    <= lz_blank_en;
         end
      end
   end

   // Walk from the most significant digit down; a digit is blanked while no enabled
   // nonzero nibble has been seen at or above it.
   always_comb begin
      lz_mask = '0;
      seen_nz = 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         seen_nz = seen_nz |
                   (snap_en[NUM_DIGITS-1-k] & (snap_value[4*(NUM_DIGITS-1-k) +: 4] != 4'h0));
         lz_mask[NUM_DIGITS-1-k] = snap_lz & ~seen_nz & (k != NUM_DIGITS - 1);
      end
   end

   assign cur_nib = snap_value[4*idx +: 4];

   ssd_hex_decoder u_hex_decoder (
      .nibble (cur_nib),
      .seg    (cur_seg)
   );

`ifdef SSD_BRIGHTNESS_PWM_EN
   assign pwm_on = (presc[SCAN_DIV_BITS-1 -: 4] < brightness) || (brightness == 4'hF);
`else
   assign pwm_on = 1'b1;
`endif

   assign visible = (presc >= BLANK_END) && snap_en[idx] && !lz_mask[idx] && pwm_on;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an         <= '1;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_wrap && (state == ST_RUN);
         if (visible) begin
            an  <= ~(AN_LSB << idx);
            seg <= cur_seg;
            dp  <= ~snap_dp[idx];
         end else begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed scoreboard bench for ssd_scan_driver: 4 digits, 16-cycle slots, 2 blank cycles.
module tb_ssd_scan_driver;

   typedef logic [127:0] tag_t;
   typedef struct {
      int         k;
      tag_t       tag;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] SC = 7'b0110001;
   localparam logic [6:0] SD = 7'b1000010;

   logic        clk;
   logic        reset_n;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        lz_blank_en;
`ifdef SSD_BRIGHTNESS_PWM_EN
   logic [3:0]  brightness;
`endif
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int   cyc    = 0;
   int   checks = 0;
   int   fails  = 0;
   exp_t sb[$];

   ssd_scan_driver #(
      .NUM_DIGITS    (4),
      .SCAN_DIV_BITS (4),
      .BLANK_CYCLES  (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .value       (value),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .lz_blank_en (lz_blank_en),
`ifdef SSD_BRIGHTNESS_PWM_EN
      .brightness  (brightness),
`endif
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input tag_t tag, input string what, input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %0s %0s got %h expected %h", tag, what, got, exp);
      end
   endtask

   task automatic check_all(input tag_t tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                            input logic e_dp, input logic e_fd);
      check(tag, "an", {4'h0, an}, {4'h0, e_an});
      check(tag, "seg", {1'b0, seg}, {1'b0, e_seg});
      check(tag, "dp", {7'h0, dp}, {7'h0, e_dp});
      check(tag, "frame_done", {7'h0, frame_done}, {7'h0, e_fd});
   endtask

   // k counts clk edges since reset release; frame_done is expected every 64th edge.
   task automatic push_lit(input int k, input int d, input logic [6:0] s, input logic dpb,
                           input tag_t tag);
      exp_t       e;
      logic [3:0] one;
      one   = 4'b0001;
      e.k   = k;
      e.tag = tag;
      e.an  = ~(one << d);
      e.seg = s;
      e.dp  = dpb;
      e.fd  = (k >= 64) && (k % 64 == 0);
      sb.push_back(e);
   endtask

   task automatic push_blank(input int k, input tag_t tag);
      exp_t e;
      e.k   = k;
      e.tag = tag;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.fd  = (k >= 64) && (k % 64 == 0);
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      int g;
      g = 0;
      while (cyc < n && g < 5000) begin
         @(negedge clk);
         g++;
      end
      checks++;
      assert (cyc >= n) else begin
         fails++;
         $error("FAIL wait_cyc got %0d expected %0d", cyc, n);
      end
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (sb.size() > 0 && g < 5000) begin
         @(negedge clk);
         g++;
      end
      checks++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL drain got %0d pending expected 0", sb.size());
      end
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (!reset_n) cyc = 0;
      else cyc++;
      while (sb.size() > 0 && sb[0].k <= cyc) begin
         e = sb.pop_front();
         if (e.k < cyc) begin
            checks++;
            fails++;
            $error("FAIL %0s missed got cycle %0d expected %0d", e.tag, cyc, e.k);
         end else begin
            check_all(e.tag, e.an, e.seg, e.dp, e.fd);
         end
      end
   end

   initial begin
      reset_n     = 1'b0;
      value       = 16'h1234;
      dp_in       = 4'b0000;
      digit_en    = 4'hF;
      lz_blank_en = 1'b0;
`ifdef SSD_BRIGHTNESS_PWM_EN
      brightness  = 4'hF;
`endif
      repeat (5) @(negedge clk);
      check_all("reset", 4'hF, 7'h7F, 1'b1, 1'b0);

      push_blank(2, "rel_blank");
      push_lit(3, 0, S4, 1'b1, "rel_d0");
      push_lit(16, 0, S4, 1'b1, "slot0_end");
      push_blank(17, "slot1_b0");
      push_blank(18, "slot1_b1");
      push_lit(19, 1, S3, 1'b1, "slot1_d1");
      push_lit(35, 2, S2, 1'b1, "slot2_d2");
      push_lit(51, 3, S1, 1'b1, "slot3_d3");
      push_lit(63, 3, S1, 1'b1, "pre_fd64");
      push_lit(64, 3, S1, 1'b1, "fd64");
      push_blank(65, "post_fd64");
      push_lit(99, 2, S2, 1'b1, "tear_d2");
      push_lit(115, 3, S1, 1'b1, "tear_d3");
      push_lit(128, 3, S1, 1'b1, "fd128");
      push_lit(131, 0, SD, 1'b1, "new_d0");
      push_lit(147, 1, SC, 1'b1, "new_d1");
      reset_n = 1'b1;

      wait_cyc(85);
      value = 16'hABCD;

      wait_cyc(140);
      value       = 16'h0050;
      lz_blank_en = 1'b1;
      push_lit(195, 0, S0, 1'b1, "lz_d0");
      push_lit(211, 1, S5, 1'b1, "lz_d1");
      push_blank(227, "lz_d2");
      push_blank(243, "lz_d3");
      push_blank(250, "lz_d3_mid");

      wait_cyc(200);
      value = 16'h0000;
      push_lit(259, 0, S0, 1'b1, "zero_d0");
      push_blank(275, "zero_d1");
      push_blank(291, "zero_d2");
      push_blank(307, "zero_d3");

      wait_cyc(260);
      digit_en = 4'hE;
      push_blank(323, "en_d0");
      push_blank(339, "en_d1");
      push_blank(355, "en_d2");
      push_blank(371, "en_d3");

      wait_cyc(330);
      value       = 16'h1234;
      digit_en    = 4'hF;
      lz_blank_en = 1'b0;
      dp_in       = 4'b0100;
      push_lit(387, 0, S4, 1'b1, "dp_d0");
      push_lit(419, 2, S2, 1'b0, "dp_d2");
      push_lit(420, 2, S2, 1'b0, "dp_d2_b");

      wait_cyc(420);
      wait_drain();
      #2;
      reset_n = 1'b0;
      #1;
      check_all("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);

      repeat (2) @(negedge clk);
      push_blank(2, "rs_blank");
      push_lit(3, 0, S4, 1'b1, "rs_d0");
      push_lit(35, 2, S2, 1'b0, "rs_dp2");
      push_lit(51, 3, S1, 1'b1, "rs_d3");
      reset_n = 1'b1;

`ifdef SSD_BRIGHTNESS_PWM_EN
      wait_cyc(40);
      brightness = 4'd8;
      push_lit(56, 3, S1, 1'b1, "pwm8_p7");
      push_blank(57, "pwm8_p8");
      wait_cyc(60);
      brightness = 4'd0;
      push_blank(67, "pwm0_p2");
      push_blank(72, "pwm0_p7");
      wait_cyc(75);
      brightness = 4'hF;
      push_lit(80, 0, S4, 1'b1, "pwm15_p15");
      push_blank(82, "pwm15_p1");
      push_lit(83, 0, S4, 1'b1, "pwm15_p2");
`endif

      wait_drain();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
